// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if : IMEM bus, pipeline control and IF/ID outputs of the fetch stage | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_stage_if;
  logic [31:0] imem_address;
  logic        imem_read_write;
  logic [31:0] imem_data_in;
  logic [31:0] imem_data_out;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_insn;
  logic        fetch_misaligned;
  logic [31:0] fetch_count;

  modport master (
    output imem_address, imem_read_write, imem_data_in,
    input  imem_data_out,
    input  stall, redirect_valid, redirect_target,
    output if_id_valid, if_id_pc, if_id_insn,
    output fetch_misaligned, fetch_count
  );

  modport slave (
    input  imem_address, imem_read_write, imem_data_in,
    output imem_data_out,
    output stall, redirect_valid, redirect_target,
    input  if_id_valid, if_id_pc, if_id_insn,
    input  fetch_misaligned, fetch_count
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage : PC, IMEM read and IF/ID register with stall/redirect/halt | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  wire logic     clock,
  input  wire logic     reset_n,
  fetch_stage_if.master bus
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic        r_if_id_valid;
  logic        w_if_id_valid_next;
  logic [31:0] r_if_id_pc;
  logic [31:0] w_if_id_pc_next;
  logic [31:0] r_if_id_insn;
  logic [31:0] w_if_id_insn_next;
  logic [31:0] r_fetch_count;
  logic [31:0] w_fetch_count_next;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Redirect outranks HALT and stall, so it is the only way out of HALT.
  always_comb begin
    w_state_next       = r_state;
    w_pc_next          = r_pc;
    w_if_id_valid_next = r_if_id_valid;
    w_if_id_pc_next    = r_if_id_pc;
    w_if_id_insn_next  = r_if_id_insn;
    w_fetch_count_next = r_fetch_count;
    if (bus.redirect_valid) begin
      w_pc_next          = bus.redirect_target;
      w_if_id_valid_next = 1'b0;
      w_if_id_pc_next    = bus.redirect_target;
      w_if_id_insn_next  = NOP_INSN;
      w_state_next       = (bus.redirect_target[1:0] != 2'b00) ? S_HALT : S_RUN;
    end else if (r_state == S_HALT) begin
      w_state_next = S_HALT;
    end else if (!bus.stall) begin
      w_if_id_valid_next = 1'b1;
      w_if_id_pc_next    = r_pc;
      w_if_id_insn_next  = bus.imem_data_out;
      w_pc_next          = r_pc + 32'd4;
      w_fetch_count_next = r_fetch_count + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= 32'h0;
      r_if_id_insn  <= NOP_INSN;
      r_fetch_count <= 32'h0;
    end else begin
      r_pc          <= w_pc_next;
      r_if_id_valid <= w_if_id_valid_next;
      r_if_id_pc    <= w_if_id_pc_next;
      r_if_id_insn  <= w_if_id_insn_next;
      r_fetch_count <= w_fetch_count_next;
    end
  end

  assign bus.imem_address     = r_pc;
  assign bus.imem_read_write  = 1'b0;
  assign bus.imem_data_in     = 32'h0;
  assign bus.if_id_valid      = r_if_id_valid;
  assign bus.if_id_pc         = r_if_id_pc;
  assign bus.if_id_insn       = r_if_id_insn;
  assign bus.fetch_misaligned = (r_state == S_HALT);
  assign bus.fetch_count      = r_fetch_count;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage : scoreboard bench for fetch_stage | Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;

  localparam logic [31:0] C_RESET_PC = 32'h0100_0000;
  localparam logic [31:0] C_NOP      = 32'h0000_0013;

  logic clock;
  logic reset_n;
  int   checks;
  int   failures;

  logic [63:0] exp_q[$];
  logic [31:0] exp_pc;
  logic [31:0] exp_count;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC (C_RESET_PC),
    .NOP_INSN (C_NOP)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory: two fixed words at the base, address-derived words elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == C_RESET_PC)              return 32'h0050_0093;
    else if (addr == C_RESET_PC + 32'd4) return 32'h0010_0113;
    else                                 return addr ^ 32'h5A5A_0013;
  endfunction

  assign bus.imem_data_out = mem_word(bus.imem_address);

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n                = 1'b0;
    bus.stall              = 1'b0;
    bus.redirect_valid     = 1'b0;
    bus.redirect_target    = 32'h0;
    tick();
    tick();
    reset_n   = 1'b1;
    exp_pc    = C_RESET_PC;
    exp_count = 32'h0;
    exp_q.delete();
  endtask

  // Free-running fetches; each expected IF/ID entry is queued before the edge.
  task automatic fetch_cycles(input int n);
    logic [63:0] e;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({exp_pc, mem_word(exp_pc)});
      exp_pc    = exp_pc + 32'd4;
      exp_count = exp_count + 32'd1;
      tick();
      e = exp_q.pop_front();
      checks++;
      if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_insn} !== {1'b1, e}) begin
        failures++;
        $display("FAIL fetch: got valid=%b pc=%h insn=%h, want valid=1 pc=%h insn=%h",
                 bus.if_id_valid, bus.if_id_pc, bus.if_id_insn, e[63:32], e[31:0]);
      end
      checks++;
      if ({bus.imem_address, bus.fetch_count} !== {exp_pc, exp_count}) begin
        failures++;
        $display("FAIL fetch_pc_count: got addr=%h count=%0d, want addr=%h count=%0d",
                 bus.imem_address, bus.fetch_count, exp_pc, exp_count);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_insn, bus.fetch_count,
         bus.fetch_misaligned, bus.imem_address, bus.imem_read_write, bus.imem_data_in}
        !== {1'b0, 32'h0, C_NOP, 32'h0, 1'b0, C_RESET_PC, 1'b0, 32'h0}) begin
      failures++;
      $display("FAIL reset: got v=%b pc=%h insn=%h cnt=%0d mis=%b addr=%h rw=%b din=%h",
               bus.if_id_valid, bus.if_id_pc, bus.if_id_insn, bus.fetch_count,
               bus.fetch_misaligned, bus.imem_address, bus.imem_read_write, bus.imem_data_in);
    end
  endtask

  task automatic test_free_run();
    do_reset();
    fetch_cycles(4);
    checks++;
    if ({bus.if_id_pc, bus.fetch_count} !== {32'h0100_000C, 32'd4}) begin
      failures++;
      $display("FAIL free_run: got pc=%h count=%0d, want pc=0100000c count=4",
               bus.if_id_pc, bus.fetch_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    fetch_cycles(2);
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bus.if_id_valid, bus.if_id_pc, bus.imem_address, bus.fetch_count}
          !== {1'b1, 32'h0100_0004, 32'h0100_0008, 32'd2}) begin
        failures++;
        $display("FAIL stall_hold: got v=%b ifpc=%h addr=%h cnt=%0d, want v=1 ifpc=01000004 addr=01000008 cnt=2",
                 bus.if_id_valid, bus.if_id_pc, bus.imem_address, bus.fetch_count);
      end
    end
    bus.stall = 1'b0;
    fetch_cycles(1);
  endtask

  task automatic test_redirect_stall();
    bus.stall           = 1'b1;
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0100_0100;
    tick();
    checks++;
    if ({bus.if_id_valid, bus.imem_address, bus.if_id_pc, bus.if_id_insn, bus.fetch_count}
        !== {1'b0, 32'h0100_0100, 32'h0100_0100, C_NOP, exp_count}) begin
      failures++;
      $display("FAIL redirect_flush: got v=%b addr=%h ifpc=%h insn=%h cnt=%0d, want v=0 addr=01000100 insn=%h cnt=%0d",
               bus.if_id_valid, bus.imem_address, bus.if_id_pc, bus.if_id_insn,
               bus.fetch_count, C_NOP, exp_count);
    end
    bus.stall          = 1'b0;
    bus.redirect_valid = 1'b0;
    exp_pc             = 32'h0100_0100;
    fetch_cycles(1);
  endtask

  task automatic test_misaligned();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0100_0102;
    tick();
    bus.redirect_valid = 1'b0;
    checks++;
    if ({bus.fetch_misaligned, bus.if_id_valid, bus.imem_address} !== {1'b1, 1'b0, 32'h0100_0102}) begin
      failures++;
      $display("FAIL misaligned_enter: got mis=%b v=%b addr=%h, want mis=1 v=0 addr=01000102",
               bus.fetch_misaligned, bus.if_id_valid, bus.imem_address);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({bus.fetch_misaligned, bus.if_id_valid, bus.imem_address, bus.fetch_count}
          !== {1'b1, 1'b0, 32'h0100_0102, exp_count}) begin
        failures++;
        $display("FAIL halt_hold: got mis=%b v=%b addr=%h cnt=%0d, want mis=1 v=0 addr=01000102 cnt=%0d",
                 bus.fetch_misaligned, bus.if_id_valid, bus.imem_address, bus.fetch_count, exp_count);
      end
    end
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0100_0200;
    tick();
    bus.redirect_valid = 1'b0;
    checks++;
    if ({bus.fetch_misaligned, bus.if_id_valid, bus.imem_address} !== {1'b0, 1'b0, 32'h0100_0200}) begin
      failures++;
      $display("FAIL halt_exit: got mis=%b v=%b addr=%h, want mis=0 v=0 addr=01000200",
               bus.fetch_misaligned, bus.if_id_valid, bus.imem_address);
    end
    exp_pc = 32'h0100_0200;
    fetch_cycles(1);
  endtask

  task automatic test_wrap();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    fetch_cycles(1);
    checks++;
    if ({bus.if_id_pc, bus.imem_address} !== {32'hFFFF_FFFC, 32'h0}) begin
      failures++;
      $display("FAIL wrap: got ifpc=%h addr=%h, want ifpc=fffffffc addr=00000000",
               bus.if_id_pc, bus.imem_address);
    end
    fetch_cycles(1);
  endtask

  task automatic test_async_reset();
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = 32'h0100_0301;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.fetch_misaligned, bus.imem_address, bus.if_id_valid, bus.if_id_pc,
         bus.if_id_insn, bus.fetch_count}
        !== {1'b0, C_RESET_PC, 1'b0, 32'h0, C_NOP, 32'h0}) begin
      failures++;
      $display("FAIL async_reset: got mis=%b addr=%h v=%b ifpc=%h insn=%h cnt=%0d",
               bus.fetch_misaligned, bus.imem_address, bus.if_id_valid, bus.if_id_pc,
               bus.if_id_insn, bus.fetch_count);
    end
    tick();
    reset_n   = 1'b1;
    exp_pc    = C_RESET_PC;
    exp_count = 32'h0;
    exp_q.delete();
    fetch_cycles(1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_free_run();
    test_stall();
    test_redirect_stall();
    test_misaligned();
    test_wrap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage RISC-V core. It owns the program counter and drives the byte address into the instruction memory, whose base is 0x01000000 and whose read path is combinational. It captures the returned instruction word, with its PC, into the IF/ID pipeline register. It also applies stall and redirect (branch/jump flush) requests from later stages and halts fetch on a misaligned redirect target.

## Interface
Parameters:
- RESET_PC, 32'h01000000, PC value loaded on reset; must be word-aligned.
- NOP_INSN, 32'h00000013, instruction word held in IF/ID when the slot is invalid (addi x0,x0,0).

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- imem_address  out  32  byte address to instruction memory; equals current PC.
- imem_read_write  out  1  tied 0 (read only).
- imem_data_in  out  32  write data to memory; tied 32'h0.
- imem_data_out  in  32  instruction word returned combinationally for imem_address.
- stall  in  1  hold PC and IF/ID contents this cycle.
- redirect_valid  in  1  load PC from redirect_target and flush IF/ID.
- redirect_target  in  32  new PC on redirect.
- if_id_valid  out  1  IF/ID slot holds a real instruction.
- if_id_pc  out  32  PC of the instruction in IF/ID.
- if_id_insn  out  32  instruction in IF/ID.
- fetch_misaligned  out  1  fetch halted on a misaligned redirect target.
- fetch_count  out  32  number of instructions written into IF/ID as valid; wraps modulo 2^32.

## Operation
- State machine, two states:
  - RUN: normal fetch.
  - HALT: misaligned target taken; no fetch.
- Registers: pc, if_id_valid, if_id_pc, if_id_insn, fetch_count, state.
- imem_address = pc, combinational from the register.
- Each rising edge, in priority order (first match wins):
  1. redirect_valid=1, in any state, stall ignored:
     - pc <= redirect_target.
     - if_id_valid <= 0; if_id_insn <= NOP_INSN; if_id_pc <= redirect_target.
     - state <= HALT if redirect_target[1:0] != 0, else RUN.
  2. state=HALT: hold all registers.
  3. stall=1: hold pc, IF/ID and fetch_count.
  4. Otherwise (RUN):
     - if_id_valid <= 1; if_id_pc <= pc; if_id_insn <= imem_data_out.
     - pc <= pc + 4, 32-bit modulo: 0xFFFFFFFC wraps to 0x00000000.
     - fetch_count <= fetch_count + 1.
- fetch_misaligned = (state == HALT), combinational from the state register.
- In HALT, if_id_valid stays 0 and imem_address still shows pc; downstream ignores it.
- Leaving HALT requires an aligned redirect or reset.
- A redirect to an aligned target gives exactly one bubble: the instruction at the target enters IF/ID on the following edge, if not stalled.

## Timing
- Reset (reset_n low, asynchronous; released synchronously by the environment):
  - pc = RESET_PC; state = RUN.
  - if_id_valid = 0; if_id_pc = 32'h0; if_id_insn = NOP_INSN.
  - fetch_count = 0; fetch_misaligned = 0; imem_address = RESET_PC.
- First valid IF/ID entry: first rising edge after reset release with stall=0. Latency PC-to-IF/ID is 1 cycle.
- Throughput: one instruction per cycle while stall=0 and redirect_valid=0.
- Stall and redirect together: redirect wins and the flush takes effect that edge.
- Reset asserted mid-stream or in HALT: all state returns to reset values immediately, without waiting for an edge.
- No combinational path from stall or redirect_* to any output.

## Test plan
- Reset then 4 free-running cycles, memory words 0x00500093, 0x00100113, ... -> if_id_pc 0x01000000, 0x01000004, 0x01000008, 0x0100000C with matching insn; fetch_count = 4.
- stall high for 3 cycles after the 2nd fetch -> IF/ID holds pc 0x01000004, pc holds 0x01000008, fetch_count holds 2; fetch resumes at 0x01000008.
- redirect_valid with target 0x01000100 while stall=1 -> next cycle if_id_valid = 0 and pc = 0x01000100; following cycle if_id_pc = 0x01000100 and valid = 1.
- redirect to 0x01000102 -> fetch_misaligned = 1, if_id_valid stays 0 for 5 cycles, fetch_count frozen; then redirect to 0x01000200 -> fetch_misaligned = 0 and a valid fetch at 0x01000200 one cycle later.
- Redirect to 0xFFFFFFFC, then 2 free-running cycles -> if_id_pc 0xFFFFFFFC, then pc = 0x00000000.
- reset_n pulsed low mid-cycle during HALT -> outputs immediately at reset values, pc = 0x01000000, fetch_misaligned = 0.
